oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
- Sequences the PPU OAM bus (0xFE00-0xFE9F) between direct CPU (Avalon) accesses and the Game Boy OAM DMA engine triggered by writes to 0xFF46.
- Sits between the CPU-side decode and the PPU's oam_a/oam_din/oam_wr/oam_rd/oam_dout port.
- Copies 160 bytes from {src_hi, 0x00..0x9F} into OAM.
- While a copy is in progress, CPU accesses to OAM are locked out.

Parameters:
- OAM_BYTES, 160, number of bytes per DMA transfer.
- OAM_BASE, 16'hFE00, first OAM address.
- DMA_REG_ADDR, 16'hFF46, DMA trigger/source register address.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  synchronous, active-low reset.
- cpu_addr  in  16  CPU address.
- cpu_rd  in  1  CPU read strobe (already qualified with chip select).
- cpu_wr  in  1  CPU write strobe (already qualified with chip select).
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  CPU read data: OAM or DMA register.
- cpu_oam_blocked  out  1  high when a CPU OAM access is being suppressed.
- src_addr  out  16  DMA source read address.
- src_rd  out  1  DMA source read strobe; data returns on src_rdata one cycle later.
- src_rdata  in  8  DMA source read data.
- oam_a  out  16  address to PPU OAM bus.
- oam_din  out  8  write data to PPU OAM bus.
- oam_rd  out  1  read strobe to PPU OAM bus.
- oam_wr  out  1  write strobe to PPU OAM bus.
- oam_dout  in  8  read data from PPU OAM bus.
- dma_busy  out  1  transfer in progress.
- dma_reg  out  8  last value written to 0xFF46.

Behaviour:
- Reset (RESET==0 at an edge):
  - state IDLE, idx=0, dma_reg=8'hFF.
  - dma_busy=0, src_rd=0, oam_wr=0.
  - Takes effect mid-transfer too; no further src_rd/oam_wr after the reset edge.
- Address decode:
  - hit_oam = cpu_addr in [OAM_BASE, OAM_BASE+OAM_BYTES-1].
  - hit_dma = (cpu_addr == DMA_REG_ADDR).
- States:
  - IDLE: no DMA activity.
  - RD: src_rd=1, src_addr=src_eff+idx.
  - WR: oam_wr=1, oam_a=OAM_BASE+idx, oam_din=src_rdata.
- Source address: src_eff={dma_reg,8'h00}, except dma_reg>=8'hE0, which maps to {dma_reg-8'h20,8'h00} (echo RAM to WRAM).
- Transitions:
  - IDLE->RD on cpu_wr&hit_dma (dma_reg<=cpu_wdata, idx<=0 at the same edge).
  - RD->WR unconditionally.
  - WR->RD with idx<=idx+1 when idx<OAM_BYTES-1.
  - WR->IDLE when idx==OAM_BYTES-1.
- Timing: trigger write sampled at edge T.
  - First RD cycle at T+1; first OAM write at T+2.
  - Last OAM write (idx 159, addr 0xFE9F) at T+320.
  - dma_busy=1 for cycles T+1..T+320 inclusive.
  - IDLE (dma_busy=0) at T+321.
- Restart: cpu_wr&hit_dma while busy:
  - dma_reg<=new value, idx<=0, state<=RD at the next edge.
  - The strobe driven in the trigger cycle still issues (a WR in that cycle writes normally); the transfer then restarts from byte 0.
- CPU pass-through when IDLE and hit_oam:
  - oam_a=cpu_addr, oam_rd=cpu_rd, oam_wr=cpu_wr, oam_din=cpu_wdata.
  - cpu_rdata=oam_dout (combinational).
- CPU lockout when dma_busy and hit_oam:
  - CPU write dropped; read returns 8'hFF.
  - cpu_oam_blocked=cpu_rd|cpu_wr; oam_* driven solely by DMA.
- Register read: cpu_rd&hit_dma returns dma_reg in any state.
- Other addresses: cpu_rdata=8'hFF, no OAM strobes.
- Strobe rules:
  - oam_rd is never asserted by DMA.
  - oam_rd and oam_wr are never asserted together.
  - src_rd is never asserted outside RD.
- idx is 8 bits and never exceeds OAM_BYTES-1; no wrap is reachable.

Decomposition:
- Shared package gb_bus_pkg:
  - state enum dma_state_t {IDLE,RD,WR}.
  - constants OAM_BASE, OAM_BYTES, DMA_REG_ADDR, ECHO_BASE (8'hE0), OPEN_BUS (8'hFF).
- One sub-module, oam_bus_mux: the combinational selection of CPU vs DMA drive for oam_* and cpu_rdata.
- The FSM, index counter and register stay in oam_dma_ctrl.

Test Plan:
- Reset then idle read of 0xFF46 -> 8'hFF; CPU write 0xFE10=8'h5A, read back -> oam_wr on 0xFE10 with 8'h5A; read returns 8'h5A; dma_busy=0.
- Write 0xFF46=8'hC1 at edge T; source model returns low byte of address -> 160 oam_wr pulses on 0xFE00..0xFE9F with data 0x00..0x9F; src_addr 0xC100..0xC19F; dma_busy high T+1..T+320 exactly.
- During that transfer, CPU read 0xFE05 and write 0xFE05=8'hAA -> cpu_rdata=8'hFF, cpu_oam_blocked=1; after completion 0xFE05 reads 8'h05.
- Write 0xFF46=8'hE2 -> src_addr starts at 0xC200; dma_reg reads 8'hE2.
- Restart: write 0xFF46=8'hC3 when idx==50 -> next RD at 0xC300; 160 further writes from 0xFE00; dma_busy continuous.
- Reset (RESET=0) at idx==80 -> next cycle dma_busy=0, no strobes; dma_reg=8'hFF; a following CPU OAM write passes through.

Source files
------------

// File: rtl/gb_bus_pkg.sv
// Shared Game Boy bus definitions for the OAM DMA path.
// Holds the DMA sequencer state encoding and the fixed bus constants:
//   OAM_BASE     first OAM byte address (0xFE00)
//   OAM_BYTES    bytes copied per DMA transfer (160)
//   DMA_REG_ADDR DMA trigger/source register address (0xFF46)
//   ECHO_BASE    source pages at or above this value are echo RAM
//   OPEN_BUS     value returned for unmapped or suppressed reads
package gb_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } dma_state_t;

  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int unsigned OAM_BYTES    = 160;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [7:0]  ECHO_BASE    = 8'hE0;
  localparam logic [7:0]  OPEN_BUS     = 8'hFF;

endpackage

// File: rtl/oam_bus_mux.sv
// Combinational owner selection for the PPU OAM bus and the CPU read path.
// While a DMA transfer is active the DMA engine owns oam_*, and CPU OAM
// accesses are suppressed (reads return open bus). When idle, CPU accesses
// that hit OAM pass straight through.
// Ports:
//   busy_i        DMA transfer in progress
//   dma_wr_i      DMA write strobe (sequencer in WR)
//   dma_addr_i    DMA OAM destination address
//   dma_din_i     DMA OAM write data
//   hit_oam_i     CPU address decodes to OAM
//   hit_dma_i     CPU address decodes to the DMA register
//   cpu_addr_i / cpu_rd_i / cpu_wr_i / cpu_wdata_i   CPU access
//   dma_reg_i     current DMA register value
//   oam_dout_i    OAM read data from the PPU
//   oam_a_o / oam_din_o / oam_rd_o / oam_wr_o        PPU OAM bus drive
//   cpu_rdata_o   CPU read data
//   cpu_oam_blocked_o  CPU OAM access being suppressed
module oam_bus_mux
  import gb_bus_pkg::*;
(
  input  logic        busy_i,
  input  logic        dma_wr_i,
  input  logic [15:0] dma_addr_i,
  input  logic [7:0]  dma_din_i,
  input  logic        hit_oam_i,
  input  logic        hit_dma_i,
  input  logic [15:0] cpu_addr_i,
  input  logic        cpu_rd_i,
  input  logic        cpu_wr_i,
  input  logic [7:0]  cpu_wdata_i,
  input  logic [7:0]  dma_reg_i,
  input  logic [7:0]  oam_dout_i,
  output logic [15:0] oam_a_o,
  output logic [7:0]  oam_din_o,
  output logic        oam_rd_o,
  output logic        oam_wr_o,
  output logic [7:0]  cpu_rdata_o,
  output logic        cpu_oam_blocked_o
);

  always_comb begin
    oam_a_o           = dma_addr_i;
    oam_din_o         = dma_din_i;
    oam_rd_o          = 1'b0;
    oam_wr_o          = 1'b0;
    cpu_rdata_o       = OPEN_BUS;
    cpu_oam_blocked_o = 1'b0;

    if (busy_i) begin
      // DMA never reads OAM, so oam_rd stays low for the whole transfer.
      oam_wr_o          = dma_wr_i;
      cpu_oam_blocked_o = hit_oam_i & (cpu_rd_i | cpu_wr_i);
    end else if (hit_oam_i) begin
      oam_a_o     = cpu_addr_i;
      oam_din_o   = cpu_wdata_i;
      oam_wr_o    = cpu_wr_i;
      // A write wins over a simultaneous read so the strobes stay exclusive.
      oam_rd_o    = cpu_rd_i & ~cpu_wr_i;
      cpu_rdata_o = oam_dout_i;
    end

    // The DMA register is readable in every state.
    if (hit_dma_i && cpu_rd_i) begin
      cpu_rdata_o = dma_reg_i;
    end
  end

endmodule

// File: rtl/oam_dma_ctrl.sv
// Game Boy OAM DMA controller. A CPU write to the DMA register latches the
// source page and copies OAM_BYTES bytes from {page,00..9F} into OAM, one
// read cycle followed by one write cycle per byte. Writing the register
// again mid-transfer restarts the copy from byte 0 with the new page.
// Ports:
//   CLK, RESET        clock, synchronous active-low reset
//   cpu_addr/cpu_rd/cpu_wr/cpu_wdata  CPU access (strobes chip-select qualified)
//   cpu_rdata         CPU read data (OAM, DMA register or open bus)
//   cpu_oam_blocked   CPU OAM access suppressed by an active transfer
//   src_addr/src_rd   DMA source read; src_rdata returns one cycle later
//   oam_a/oam_din/oam_rd/oam_wr/oam_dout  PPU OAM bus
//   dma_busy          transfer in progress
//   dma_reg           last value written to the DMA register
module oam_dma_ctrl #(
  parameter int unsigned OAM_BYTES    = gb_bus_pkg::OAM_BYTES,
  parameter logic [15:0] OAM_BASE     = gb_bus_pkg::OAM_BASE,
  parameter logic [15:0] DMA_REG_ADDR = gb_bus_pkg::DMA_REG_ADDR
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_oam_blocked,
  output logic [15:0] src_addr,
  output logic        src_rd,
  input  logic [7:0]  src_rdata,
  output logic [15:0] oam_a,
  output logic [7:0]  oam_din,
  output logic        oam_rd,
  output logic        oam_wr,
  input  logic [7:0]  oam_dout,
  output logic        dma_busy,
  output logic [7:0]  dma_reg
);

  import gb_bus_pkg::*;

  localparam logic [7:0]  IDX_LAST = 8'(OAM_BYTES - 1);
  localparam logic [15:0] OAM_END  = 16'(OAM_BASE + 16'(OAM_BYTES - 1));

  dma_state_t  state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  dma_reg_q, dma_reg_d;

  logic        hit_oam;
  logic        hit_dma;
  logic        trig;
  logic        dma_wr;
  logic [7:0]  src_page;

  assign hit_oam  = (cpu_addr >= OAM_BASE) && (cpu_addr <= OAM_END);
  assign hit_dma  = (cpu_addr == DMA_REG_ADDR);
  assign trig     = cpu_wr & hit_dma;
  assign dma_busy = (state_q != IDLE);
  assign dma_reg  = dma_reg_q;

  // Echo RAM pages (E0..FF) mirror WRAM 0x20 pages lower.
  assign src_page = (dma_reg_q >= ECHO_BASE) ? (dma_reg_q - 8'h20) : dma_reg_q;
  assign src_addr = {src_page, 8'h00} + {8'h00, idx_q};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dma_reg_d = dma_reg_q;
    src_rd    = 1'b0;
    dma_wr    = 1'b0;

    case (state_q)
      IDLE: ;
      RD: begin
        src_rd  = 1'b1;
        state_d = WR;
      end
      WR: begin
        dma_wr = 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = IDLE;
        end else begin
          state_d = RD;
          idx_d   = idx_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A register write starts or restarts the copy; the strobe already
    // driven this cycle still completes.
    if (trig) begin
      dma_reg_d = cpu_wdata;
      idx_d     = 8'd0;
      state_d   = RD;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= IDLE;
      idx_q     <= 8'd0;
      dma_reg_q <= OPEN_BUS;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dma_reg_q <= dma_reg_d;
    end
  end

  oam_bus_mux u_mux (
    .busy_i            (dma_busy),
    .dma_wr_i          (dma_wr),
    .dma_addr_i        (OAM_BASE + {8'h00, idx_q}),
    .dma_din_i         (src_rdata),
    .hit_oam_i         (hit_oam),
    .hit_dma_i         (hit_dma),
    .cpu_addr_i        (cpu_addr),
    .cpu_rd_i          (cpu_rd),
    .cpu_wr_i          (cpu_wr),
    .cpu_wdata_i       (cpu_wdata),
    .dma_reg_i         (dma_reg_q),
    .oam_dout_i        (oam_dout),
    .oam_a_o           (oam_a),
    .oam_din_o         (oam_din),
    .oam_rd_o          (oam_rd),
    .oam_wr_o          (oam_wr),
    .cpu_rdata_o       (cpu_rdata),
    .cpu_oam_blocked_o (cpu_oam_blocked)
  );

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic        cpu_oam_blocked;
  logic [15:0] src_addr;
  logic        src_rd;
  logic [7:0]  src_rdata = 8'h00;
  logic [15:0] oam_a;
  logic [7:0]  oam_din;
  logic        oam_rd;
  logic        oam_wr;
  logic [7:0]  oam_dout;
  logic        dma_busy;
  logic [7:0]  dma_reg;

  int checks = 0;
  int errors = 0;

  // PPU OAM model and source memory model (returns low address byte).
  logic [7:0]  oam_mem [0:159];
  logic [15:0] oam_off;
  logic        oam_in_range;
  assign oam_off      = oam_a - 16'hFE00;
  assign oam_in_range = (oam_a >= 16'hFE00) && (oam_a <= 16'hFE9F);
  assign oam_dout     = oam_in_range ? oam_mem[oam_off[7:0]] : 8'h00;

  always @(posedge CLK) begin
    src_rdata <= src_rd ? src_addr[7:0] : 8'h00;
    if (oam_wr && oam_in_range) oam_mem[oam_off[7:0]] <= oam_din;
  end

  always #5 CLK = ~CLK;

  oam_dma_ctrl dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .cpu_addr        (cpu_addr),
    .cpu_rd          (cpu_rd),
    .cpu_wr          (cpu_wr),
    .cpu_wdata       (cpu_wdata),
    .cpu_rdata       (cpu_rdata),
    .cpu_oam_blocked (cpu_oam_blocked),
    .src_addr        (src_addr),
    .src_rd          (src_rd),
    .src_rdata       (src_rdata),
    .oam_a           (oam_a),
    .oam_din         (oam_din),
    .oam_rd          (oam_rd),
    .oam_wr          (oam_wr),
    .oam_dout        (oam_dout),
    .dma_busy        (dma_busy),
    .dma_reg         (dma_reg)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cpu();
    cpu_addr  = 16'h0000;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    cpu_wdata = 8'h00;
  endtask

  task automatic trigger(input logic [7:0] page);
    cpu_addr  = 16'hFF46;
    cpu_wdata = page;
    cpu_wr    = 1'b1;
    cpu_rd    = 1'b0;
    step();
    idle_cpu();
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    idle_cpu();
    step();
    step();
    RESET = 1'b1;
    #1;
    checks++;
    if (dma_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h want 0", dma_busy); end
    checks++;
    if (src_rd !== 1'b0) begin errors++; $display("FAIL reset_src_rd got %0h want 0", src_rd); end
    checks++;
    if (oam_wr !== 1'b0) begin errors++; $display("FAIL reset_oam_wr got %0h want 0", oam_wr); end
    checks++;
    if (dma_reg !== 8'hFF) begin errors++; $display("FAIL reset_dma_reg got %02h want ff", dma_reg); end
    cpu_addr = 16'hFF46;
    cpu_rd   = 1'b1;
    #1;
    checks++;
    if (cpu_rdata !== 8'hFF) begin errors++; $display("FAIL reset_reg_read got %02h want ff", cpu_rdata); end
    step();
    idle_cpu();
  endtask

  task automatic test_cpu_passthru();
    cpu_addr  = 16'hFE10;
    cpu_wdata = 8'h5A;
    cpu_wr    = 1'b1;
    #1;
    checks++;
    if (oam_wr !== 1'b1 || oam_rd !== 1'b0) begin errors++; $display("FAIL pt_wr_strobe got wr=%0h rd=%0h want wr=1 rd=0", oam_wr, oam_rd); end
    checks++;
    if (oam_a !== 16'hFE10 || oam_din !== 8'h5A) begin errors++; $display("FAIL pt_wr_bus got a=%04h d=%02h want a=fe10 d=5a", oam_a, oam_din); end
    checks++;
    if (cpu_oam_blocked !== 1'b0) begin errors++; $display("FAIL pt_blocked got %0h want 0", cpu_oam_blocked); end
    step();
    cpu_wr = 1'b0;
    cpu_rd = 1'b1;
    #1;
    checks++;
    if (oam_rd !== 1'b1 || oam_wr !== 1'b0) begin errors++; $display("FAIL pt_rd_strobe got rd=%0h wr=%0h want rd=1 wr=0", oam_rd, oam_wr); end
    checks++;
    if (cpu_rdata !== 8'h5A) begin errors++; $display("FAIL pt_readback got %02h want 5a", cpu_rdata); end
    checks++;
    if (dma_busy !== 1'b0) begin errors++; $display("FAIL pt_busy got %0h want 0", dma_busy); end
    cpu_addr = 16'hFEA0;
    #1;
    checks++;
    if (oam_rd !== 1'b0 || cpu_rdata !== 8'hFF) begin errors++; $display("FAIL pt_outside got rd=%0h data=%02h want rd=0 data=ff", oam_rd, cpu_rdata); end
    step();
    idle_cpu();
  endtask

  task automatic test_dma_transfer();
    trigger(8'hC1);
    for (int i = 0; i < 320; i++) begin
      idle_cpu();
      if (i == 20) begin
        cpu_addr = 16'hFE05;
        cpu_rd   = 1'b1;
      end else if (i == 21) begin
        cpu_addr  = 16'hFE05;
        cpu_wdata = 8'hAA;
        cpu_wr    = 1'b1;
      end
      #1;
      checks++;
      if (dma_busy !== 1'b1) begin errors++; $display("FAIL dma_busy cyc=%0d got %0h want 1", i, dma_busy); end
      checks++;
      if (oam_rd !== 1'b0) begin errors++; $display("FAIL dma_oam_rd cyc=%0d got %0h want 0", i, oam_rd); end
      if (i % 2 == 0) begin
        checks++;
        if (src_rd !== 1'b1 || oam_wr !== 1'b0 || src_addr !== (16'hC100 + 16'(i / 2))) begin
          errors++;
          $display("FAIL dma_rd cyc=%0d got src_rd=%0h oam_wr=%0h src=%04h want 1 0 %04h", i, src_rd, oam_wr, src_addr, 16'hC100 + 16'(i / 2));
        end
      end else begin
        checks++;
        if (oam_wr !== 1'b1 || src_rd !== 1'b0 || oam_a !== (16'hFE00 + 16'(i / 2)) || oam_din !== 8'(i / 2)) begin
          errors++;
          $display("FAIL dma_wr cyc=%0d got wr=%0h src_rd=%0h a=%04h d=%02h want 1 0 %04h %02h", i, oam_wr, src_rd, oam_a, oam_din, 16'hFE00 + 16'(i / 2), 8'(i / 2));
        end
      end
      if (i == 20) begin
        checks++;
        if (cpu_rdata !== 8'hFF || cpu_oam_blocked !== 1'b1) begin errors++; $display("FAIL lock_read got data=%02h blk=%0h want ff 1", cpu_rdata, cpu_oam_blocked); end
      end
      if (i == 21) begin
        checks++;
        if (cpu_oam_blocked !== 1'b1) begin errors++; $display("FAIL lock_write got blk=%0h want 1", cpu_oam_blocked); end
      end
      step();
    end
    idle_cpu();
    #1;
    checks++;
    if (dma_busy !== 1'b0 || src_rd !== 1'b0 || oam_wr !== 1'b0) begin errors++; $display("FAIL dma_done got busy=%0h src_rd=%0h wr=%0h want 0 0 0", dma_busy, src_rd, oam_wr); end
    cpu_addr = 16'hFE05;
    cpu_rd   = 1'b1;
    #1;
    checks++;
    if (cpu_rdata !== 8'h05) begin errors++; $display("FAIL dma_fe05 got %02h want 05", cpu_rdata); end
    cpu_addr = 16'hFE9F;
    #1;
    checks++;
    if (cpu_rdata !== 8'h9F) begin errors++; $display("FAIL dma_fe9f got %02h want 9f", cpu_rdata); end
    cpu_addr = 16'hFE00;
    #1;
    checks++;
    if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL dma_fe00 got %02h want 00", cpu_rdata); end
    step();
    idle_cpu();
  endtask

  task automatic test_echo();
    int n;
    trigger(8'hE2);
    #1;
    checks++;
    if (src_rd !== 1'b1 || src_addr !== 16'hC200) begin errors++; $display("FAIL echo_src got rd=%0h a=%04h want 1 c200", src_rd, src_addr); end
    cpu_addr = 16'hFF46;
    cpu_rd   = 1'b1;
    #1;
    checks++;
    if (cpu_rdata !== 8'hE2 || dma_reg !== 8'hE2) begin errors++; $display("FAIL echo_reg got rdata=%02h reg=%02h want e2 e2", cpu_rdata, dma_reg); end
    idle_cpu();
    n = 0;
    while (dma_busy && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (dma_busy !== 1'b0) begin errors++; $display("FAIL echo_timeout got busy=%0h want 0", dma_busy); end
  endtask

  task automatic test_back_to_back();
    int          wr_cnt;
    logic [15:0] last_a;
    trigger(8'hC4);
    for (int i = 0; i < 101; i++) step();
    cpu_addr  = 16'hFF46;
    cpu_wdata = 8'hC3;
    cpu_wr    = 1'b1;
    #1;
    checks++;
    if (oam_wr !== 1'b1 || oam_a !== 16'hFE32 || oam_din !== 8'h32) begin errors++; $display("FAIL rst_pending_wr got wr=%0h a=%04h d=%02h want 1 fe32 32", oam_wr, oam_a, oam_din); end
    step();
    idle_cpu();
    wr_cnt = 0;
    last_a = 16'h0000;
    for (int j = 0; j < 320; j++) begin
      #1;
      checks++;
      if (dma_busy !== 1'b1) begin errors++; $display("FAIL rst_busy cyc=%0d got %0h want 1", j, dma_busy); end
      if (j == 0) begin
        checks++;
        if (src_rd !== 1'b1 || src_addr !== 16'hC300) begin errors++; $display("FAIL rst_first_rd got rd=%0h a=%04h want 1 c300", src_rd, src_addr); end
      end
      if (j == 1) begin
        checks++;
        if (oam_wr !== 1'b1 || oam_a !== 16'hFE00 || oam_din !== 8'h00) begin errors++; $display("FAIL rst_first_wr got wr=%0h a=%04h d=%02h want 1 fe00 00", oam_wr, oam_a, oam_din); end
      end
      if (oam_wr) begin
        wr_cnt++;
        last_a = oam_a;
      end
      step();
    end
    #1;
    checks++;
    if (wr_cnt != 160 || last_a !== 16'hFE9F) begin errors++; $display("FAIL rst_writes got cnt=%0d last=%04h want 160 fe9f", wr_cnt, last_a); end
    checks++;
    if (dma_busy !== 1'b0) begin errors++; $display("FAIL rst_done got busy=%0h want 0", dma_busy); end
  endtask

  task automatic test_reset_mid();
    trigger(8'hC1);
    for (int i = 0; i < 160; i++) step();
    #1;
    checks++;
    if (src_rd !== 1'b1 || src_addr !== 16'hC150) begin errors++; $display("FAIL mid_pre got rd=%0h a=%04h want 1 c150", src_rd, src_addr); end
    RESET = 1'b0;
    step();
    RESET = 1'b1;
    #1;
    checks++;
    if (dma_busy !== 1'b0 || src_rd !== 1'b0 || oam_wr !== 1'b0) begin errors++; $display("FAIL mid_after got busy=%0h src_rd=%0h wr=%0h want 0 0 0", dma_busy, src_rd, oam_wr); end
    step();
    checks++;
    if (dma_busy !== 1'b0 || src_rd !== 1'b0 || oam_wr !== 1'b0) begin errors++; $display("FAIL mid_quiet got busy=%0h src_rd=%0h wr=%0h want 0 0 0", dma_busy, src_rd, oam_wr); end
    cpu_addr = 16'hFF46;
    cpu_rd   = 1'b1;
    #1;
    checks++;
    if (cpu_rdata !== 8'hFF) begin errors++; $display("FAIL mid_reg got %02h want ff", cpu_rdata); end
    cpu_rd    = 1'b0;
    cpu_addr  = 16'hFE20;
    cpu_wdata = 8'h77;
    cpu_wr    = 1'b1;
    #1;
    checks++;
    if (oam_wr !== 1'b1 || oam_a !== 16'hFE20 || oam_din !== 8'h77) begin errors++; $display("FAIL mid_cpu_wr got wr=%0h a=%04h d=%02h want 1 fe20 77", oam_wr, oam_a, oam_din); end
    step();
    cpu_wr = 1'b0;
    cpu_rd = 1'b1;
    #1;
    checks++;
    if (cpu_rdata !== 8'h77) begin errors++; $display("FAIL mid_readback got %02h want 77", cpu_rdata); end
    step();
    idle_cpu();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_passthru();
    test_dma_transfer();
    test_echo();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
